// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES block types and the initial/final permutation functions
package des_pkg;

  typedef logic [31:0] des_half_t;
  typedef logic [63:0] des_block_t;

  localparam int DES_BLOCK_W = 64;

  // Final permutation IP^-1: the two halves interleave column-wise; bit 63 is DES bit 1.
  function automatic des_block_t des_fp_f(input des_half_t h, input des_half_t lo);
    des_block_t blk;
    blk = '0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 8; b++) begin
        blk[(6 - 2*a) + 8*b] = h[31 - 8*a - b];
        blk[(7 - 2*a) + 8*b] = lo[31 - 8*a - b];
      end
    end
    return blk;
  endfunction

  // Forward initial permutation IP: exact inverse of des_fp_f, returns {L, R}.
  function automatic des_block_t des_ip_f(input des_block_t blk);
    des_half_t h;
    des_half_t lo;
    h  = '0;
    lo = '0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 8; b++) begin
        h[31 - 8*a - b]  = blk[(6 - 2*a) + 8*b];
        lo[31 - 8*a - b] = blk[(7 - 2*a) + 8*b];
      end
    end
    return {h, lo};
  endfunction

endpackage

// File: rtl/des_skid_buf.sv
// rtl/des_skid_buf.sv - generic 2-entry valid/ready skid buffer (output register + skid entry)
module des_skid_buf #(
  parameter int W = 64
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] or_q, or_d;
  logic         or_valid_q, or_valid_d;
  logic [W-1:0] sk_q, sk_d;
  logic         sk_valid_q, sk_valid_d;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = in_valid_i && !sk_valid_q;
  assign out_fire = or_valid_q && out_ready_i;

  // Next-state: refill the output register from skid first, else from input; overflow into skid.
  always_comb begin
    or_d       = or_q;
    or_valid_d = or_valid_q;
    sk_d       = sk_q;
    sk_valid_d = sk_valid_q;
    if (!or_valid_q || out_fire) begin
      if (sk_valid_q) begin
        or_d       = sk_q;
        or_valid_d = 1'b1;
        sk_valid_d = 1'b0;
        if (in_fire) begin
          sk_d       = in_data_i;
          sk_valid_d = 1'b1;
        end
      end else if (in_fire) begin
        or_d       = in_data_i;
        or_valid_d = 1'b1;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      sk_d       = in_data_i;
      sk_valid_d = 1'b1;
    end
  end

  // Storage registers; reset discards both entries.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      or_q       <= '0;
      or_valid_q <= 1'b0;
      sk_q       <= '0;
      sk_valid_q <= 1'b0;
    end else begin
      or_q       <= or_d;
      or_valid_q <= or_valid_d;
      sk_q       <= sk_d;
      sk_valid_q <= sk_valid_d;
    end
  end

  // Ready comes straight from a flop so the upstream path stays short.
  assign in_ready_o  = !sk_valid_q;
  assign out_data_o  = or_q;
  assign out_valid_o = or_valid_q;

endmodule

// File: rtl/des_fp.sv
// rtl/des_fp.sv - DES final permutation stage with skid-buffered handshake (optional self-check: DES_FP_SELFCHECK_EN)
module des_fp
  import des_pkg::*;
#(
  parameter bit SWAP_HALVES = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [31:0]      left_data_in,
  input  logic [31:0]      right_data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic [63:0]      data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic [CNT_W-1:0] blk_cnt_out,
  output logic             err_out
);

  des_block_t pre;
  des_block_t blk;

  // Pre-output ordering (R16L16 when swapping) followed by the final permutation.
  always_comb begin
    pre = SWAP_HALVES ? {right_data_in, left_data_in} : {left_data_in, right_data_in};
    blk = des_fp_f(pre[63:32], pre[31:0]);
  end

`ifdef DES_FP_SELFCHECK_EN
  // The source halves travel alongside the permuted block so the checker can see them at OR.
  localparam int PAY_W = 2 * DES_BLOCK_W;
  logic [PAY_W-1:0] in_payload;
  assign in_payload = {blk, pre};
`else
  localparam int PAY_W = DES_BLOCK_W;
  logic [PAY_W-1:0] in_payload;
  assign in_payload = blk;
`endif

  logic [PAY_W-1:0] out_payload;

  des_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .in_data_i   (in_payload),
    .in_valid_i  (data_in_valid),
    .in_ready_o  (data_in_ready),
    .out_data_o  (out_payload),
    .out_valid_o (data_out_valid),
    .out_ready_i (data_out_ready)
  );

  assign data_out = out_payload[PAY_W-1 -: DES_BLOCK_W];

  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

  // Delivered-block counter, wraps naturally at 2^CNT_W.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (data_out_valid && data_out_ready) begin
      blk_cnt_d = blk_cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign blk_cnt_out = blk_cnt_q;

`ifdef DES_FP_SELFCHECK_EN
  logic       err_q, err_d;
  des_block_t chk_halves;

  // Re-run IP on the block held in OR and compare with the halves that produced it.
  always_comb begin
    chk_halves = des_ip_f(out_payload[PAY_W-1 -: DES_BLOCK_W]);
    err_d      = err_q | (data_out_valid && (chk_halves != out_payload[DES_BLOCK_W-1:0]));
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_des_fp.sv
// tb/tb_des_fp.sv - self-checking bench for des_fp against a DES IP^-1 table model
module tb_des_fp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;

  logic [31:0] l1 = '0, r1 = '0;
  logic        v1 = 1'b0, ordy1 = 1'b0;
  logic        rdy_in1, vout1, err1;
  logic [63:0] dout1;
  logic [15:0] cnt1;

  logic [31:0] l0 = '0, r0 = '0;
  logic        v0 = 1'b0, ordy0 = 1'b0;
  logic        rdy_in0, vout0, err0;
  logic [63:0] dout0;
  logic [15:0] cnt0;

  int passes = 0;
  int total  = 0;

  des_fp #(.SWAP_HALVES(1'b1), .CNT_W(16)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n),
    .left_data_in(l1), .right_data_in(r1),
    .data_in_valid(v1), .data_in_ready(rdy_in1),
    .data_out(dout1), .data_out_valid(vout1), .data_out_ready(ordy1),
    .blk_cnt_out(cnt1), .err_out(err1)
  );

  des_fp #(.SWAP_HALVES(1'b0), .CNT_W(16)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n),
    .left_data_in(l0), .right_data_in(r0),
    .data_in_valid(v0), .data_in_ready(rdy_in0),
    .data_out(dout0), .data_out_valid(vout0), .data_out_ready(ordy0),
    .blk_cnt_out(cnt0), .err_out(err0)
  );

  // Standard DES IP^-1 table: output bit i (1 = MSB) takes pre-output bit fp_tab[i-1].
  int fp_tab [0:63] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  function automatic logic [63:0] fp_ref(input logic [63:0] p);
    logic [63:0] o;
    o = '0;
    for (int i = 1; i <= 64; i++) o[64 - i] = p[64 - fp_tab[i-1]];
    return o;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    v1 = 1'b0; v0 = 1'b0; ordy1 = 1'b0; ordy0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (dout1 !== 64'h0) $display("FAIL reset_data_out: got %h want %h", dout1, 64'h0); else passes++;
    total++; if (vout1 !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", vout1); else passes++;
    total++; if (rdy_in1 !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", rdy_in1); else passes++;
    total++; if (cnt1 !== 16'h0) $display("FAIL reset_cnt: got %0d want 0", cnt1); else passes++;
    total++; if (err1 !== 1'b0) $display("FAIL reset_err: got %b want 0", err1); else passes++;
    total++; if (vout0 !== 1'b0) $display("FAIL reset_out_valid_noswap: got %b want 0", vout0); else passes++;
  endtask

  task automatic test_vector();
    apply_reset();
    ordy0 = 1'b1; ordy1 = 1'b1;
    l0 = 32'hCC00CCFF; r0 = 32'hF0AAF0AA; v0 = 1'b1;
    l1 = 32'hF0AAF0AA; r1 = 32'hCC00CCFF; v1 = 1'b1;
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    total++; if (dout0 !== 64'h0123456789ABCDEF) $display("FAIL vec_noswap: got %h want 0123456789abcdef", dout0); else passes++;
    total++; if (dout1 !== 64'h0123456789ABCDEF) $display("FAIL vec_swap: got %h want 0123456789abcdef", dout1); else passes++;
    total++; if (vout1 !== 1'b1) $display("FAIL vec_latency_valid: got %b want 1", vout1); else passes++;
    @(negedge clk);
    total++; if (cnt0 !== 16'd1) $display("FAIL vec_cnt_noswap: got %0d want 1", cnt0); else passes++;
    total++; if (cnt1 !== 16'd1) $display("FAIL vec_cnt_swap: got %0d want 1", cnt1); else passes++;
    total++; if (vout1 !== 1'b0) $display("FAIL vec_valid_drop: got %b want 0", vout1); else passes++;
    total++; if (dout1 !== 64'h0123456789ABCDEF) $display("FAIL vec_idle_hold: got %h want 0123456789abcdef", dout1); else passes++;
  endtask

  task automatic test_walk();
    logic [63:0] p;
    apply_reset();
    ordy1 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      p = 64'd1 << i;
      {r1, l1} = p;
      v1 = 1'b1;
      @(negedge clk);
      v1 = 1'b0;
      total++; if (dout1 !== fp_ref(p)) $display("FAIL walk_bit%0d: got %h want %h", i, dout1, fp_ref(p)); else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] beats [8];
    logic [63:0] held;
    int acc;
    int got;
    logic in_f;
    logic out_f;
    acc = 0; got = 0; held = '0;
    apply_reset();
    ordy1 = 1'b0;
    for (int i = 0; i < 8; i++) beats[i] = {$urandom, $urandom};
    for (int c = 0; c < 8; c++) begin
      if (acc < 8) begin v1 = 1'b1; {r1, l1} = beats[acc]; end
      if (c == 1) held = dout1;
      if (c == 2) begin
        total++; if (rdy_in1 !== 1'b0) $display("FAIL b2b_ready_low: got %b want 0", rdy_in1); else passes++;
      end
      if (v1 && rdy_in1) acc++;
      @(negedge clk);
    end
    total++; if (acc !== 2) $display("FAIL b2b_accepted: got %0d want 2", acc); else passes++;
    total++; if (held !== fp_ref(beats[0])) $display("FAIL b2b_first: got %h want %h", held, fp_ref(beats[0])); else passes++;
    total++; if (dout1 !== held) $display("FAIL b2b_stable: got %h want %h", dout1, held); else passes++;
    ordy1 = 1'b1;
    for (int c = 0; c < 60 && got < 8; c++) begin
      if (acc < 8) begin v1 = 1'b1; {r1, l1} = beats[acc]; end else v1 = 1'b0;
      in_f  = v1 && rdy_in1;
      out_f = vout1 && ordy1;
      if (out_f) begin
        total++; if (dout1 !== fp_ref(beats[got])) $display("FAIL b2b_order%0d: got %h want %h", got, dout1, fp_ref(beats[got])); else passes++;
        got++;
      end
      if (in_f) acc++;
      @(negedge clk);
    end
    v1 = 1'b0;
    total++; if (got !== 8) $display("FAIL b2b_delivered: got %0d want 8", got); else passes++;
    total++; if (cnt1 !== 16'd8) $display("FAIL b2b_cnt: got %0d want 8", cnt1); else passes++;
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [63:0] exp_q [$];
    logic [63:0] want;
    logic [63:0] prev_data;
    logic prev_stall;
    logic last_in;
    int sent;
    int done;
    sent = 0; done = 0; prev_stall = 1'b0; prev_data = '0; last_in = 1'b0;
    apply_reset();
    for (int c = 0; c < 60000 && done < N; c++) begin
      if (prev_stall) begin
        total++; if (dout1 !== prev_data) $display("FAIL rand_stall_stable: got %h want %h", dout1, prev_data); else passes++;
      end
      if (!v1 || last_in) begin
        if (sent < N && $urandom_range(3) != 0) begin
          v1 = 1'b1;
          l1 = $urandom;
          r1 = $urandom;
        end else begin
          v1 = 1'b0;
        end
      end
      ordy1 = ($urandom_range(3) != 0);
      if (vout1 && ordy1) begin
        if (exp_q.size() == 0) begin
          total++; $display("FAIL rand_spurious: got %h want nothing", dout1);
        end else begin
          want = exp_q.pop_front();
          total++; if (dout1 !== want) $display("FAIL rand_block%0d: got %h want %h", done, dout1, want); else passes++;
        end
        done++;
      end
      last_in = v1 && rdy_in1;
      if (last_in) begin
        exp_q.push_back(fp_ref({r1, l1}));
        sent++;
      end
      prev_stall = vout1 && !ordy1;
      prev_data  = dout1;
      @(negedge clk);
    end
    v1 = 1'b0; ordy1 = 1'b0;
    total++; if (done !== N) $display("FAIL rand_delivered: got %0d want %0d", done, N); else passes++;
    total++; if (cnt1 !== 16'(N)) $display("FAIL rand_cnt: got %0d want %0d", cnt1, N); else passes++;
    total++; if (exp_q.size() !== 0) $display("FAIL rand_leftover: got %0d want 0", exp_q.size()); else passes++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ordy1 = 1'b1; v1 = 1'b1; {r1, l1} = {$urandom, $urandom};
    @(negedge clk);
    {r1, l1} = {$urandom, $urandom};
    @(negedge clk);
    ordy1 = 1'b0; {r1, l1} = {$urandom, $urandom};
    @(negedge clk);
    v1 = 1'b0;
    total++; if (rdy_in1 !== 1'b0) $display("FAIL mid_pre_ready: got %b want 0", rdy_in1); else passes++;
    total++; if (cnt1 !== 16'd1) $display("FAIL mid_pre_cnt: got %0d want 1", cnt1); else passes++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (dout1 !== 64'h0) $display("FAIL mid_data_out: got %h want 0", dout1); else passes++;
    total++; if (vout1 !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", vout1); else passes++;
    total++; if (rdy_in1 !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", rdy_in1); else passes++;
    total++; if (cnt1 !== 16'd0) $display("FAIL mid_cnt: got %0d want 0", cnt1); else passes++;
    @(negedge clk);
    rst_n = 1'b1; ordy1 = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (vout1) seen++;
      end
      total++; if (seen !== 0) $display("FAIL mid_stale: got %0d valid cycles want 0", seen); else passes++;
    end
  endtask

  task automatic test_selfcheck();
`ifdef DES_FP_SELFCHECK_EN
    logic [63:0]  beat;
    logic [127:0] forced;
    apply_reset();
    ordy1 = 1'b0;
    beat = {$urandom, $urandom};
    {r1, l1} = beat; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    total++; if (err1 !== 1'b0) $display("FAIL chk_clean: got %b want 0", err1); else passes++;
    forced = {fp_ref(beat) ^ 64'h1, beat};
    force dut1.u_skid.or_q = forced;
    @(negedge clk);
    release dut1.u_skid.or_q;
    @(negedge clk);
    total++; if (err1 !== 1'b1) $display("FAIL chk_detect: got %b want 1", err1); else passes++;
    ordy1 = 1'b1; v1 = 1'b1; {r1, l1} = {$urandom, $urandom};
    for (int c = 0; c < 4; c++) @(negedge clk);
    v1 = 1'b0;
    total++; if (err1 !== 1'b1) $display("FAIL chk_sticky: got %b want 1", err1); else passes++;
    apply_reset();
    total++; if (err1 !== 1'b0) $display("FAIL chk_reset: got %b want 0", err1); else passes++;
`else
    total++; if (err1 !== 1'b0) $display("FAIL err_tied_swap: got %b want 0", err1); else passes++;
    total++; if (err0 !== 1'b0) $display("FAIL err_tied_noswap: got %b want 0", err0); else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_vector();
    test_walk();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_selfcheck();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
